// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and packed-bus helper for the gemm frame sequencer.
package fft_pkg;

    localparam int EXP_WIDTH    = 4;
    localparam int SIG_WIDTH    = 4;
    localparam int FORMAT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int POINTS       = 4;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        DRAIN
    } seq_state_t;

    // Slot k of a four-sample bus lives at bits [k*FORMAT_WIDTH +: FORMAT_WIDTH].
    function automatic logic [FORMAT_WIDTH-1:0] get_slot(
        input logic [POINTS*FORMAT_WIDTH-1:0] bus,
        input logic [1:0]                     k
    );
        return bus[k*FORMAT_WIDTH +: FORMAT_WIDTH];
    endfunction

endpackage

// File: rtl/gemm_frame_sequencer_if.sv
// Sample stream, result stream and gemm start/done bus seen by the frame sequencer.
interface gemm_frame_sequencer_if
    import fft_pkg::*;
#(
    parameter int formatWidth = FORMAT_WIDTH
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [formatWidth-1:0]        in_real;
    logic [formatWidth-1:0]        in_imag;
    logic                          start;
    logic [POINTS*formatWidth-1:0] input_real;
    logic [POINTS*formatWidth-1:0] input_imag;
    logic [POINTS*formatWidth-1:0] output_real;
    logic [POINTS*formatWidth-1:0] output_imag;
    logic                          gemm_done;
    logic                          out_valid;
    logic                          out_ready;
    logic [formatWidth-1:0]        out_real;
    logic [formatWidth-1:0]        out_imag;
    logic                          out_last;
    logic                          busy;
    logic                          error;

    modport master (
        input  in_valid, in_real, in_imag, output_real, output_imag, gemm_done, out_ready,
        output in_ready, start, input_real, input_imag, out_valid, out_real, out_imag,
               out_last, busy, error
    );

    modport slave (
        output in_valid, in_real, in_imag, output_real, output_imag, gemm_done, out_ready,
        input  in_ready, start, input_real, input_imag, out_valid, out_real, out_imag,
               out_last, busy, error
    );

endinterface

// File: rtl/frame_buffer4.sv
// Four-entry complex register file: single-slot write, whole-frame load, packed read port.
module frame_buffer4
    import fft_pkg::*;
#(
    parameter int formatWidth = FORMAT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [1:0]                    wr_slot,
    input  logic [formatWidth-1:0]        wr_real,
    input  logic [formatWidth-1:0]        wr_imag,
    input  logic                          load_en,
    input  logic [POINTS*formatWidth-1:0] load_real,
    input  logic [POINTS*formatWidth-1:0] load_imag,
    output logic [POINTS*formatWidth-1:0] rd_real,
    output logic [POINTS*formatWidth-1:0] rd_imag
);

    logic [POINTS*formatWidth-1:0] real_q;
    logic [POINTS*formatWidth-1:0] imag_q;

    // A whole-frame load wins over a single-slot write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            real_q <= '0;
            imag_q <= '0;
        end else if (load_en) begin
            real_q <= load_real;
            imag_q <= load_imag;
        end else if (wr_en) begin
            real_q[wr_slot*formatWidth +: formatWidth] <= wr_real;
            imag_q[wr_slot*formatWidth +: formatWidth] <= wr_imag;
        end
    end

    assign rd_real = real_q;
    assign rd_imag = imag_q;

endmodule

// File: rtl/gemm_frame_sequencer.sv
// Packs four stream samples for the gemm kernel, runs start/done, streams four results back.
// Optional watchdog on the gemm wait: define GEMM_FRAME_SEQUENCER_TIMEOUT_EN.
module gemm_frame_sequencer
    import fft_pkg::*;
#(
    parameter int expWidth       = EXP_WIDTH,
    parameter int sigWidth       = SIG_WIDTH,
    parameter int formatWidth    = 1 + expWidth + sigWidth
`ifdef GEMM_FRAME_SEQUENCER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic                    clk,
    input logic                    rst,
    gemm_frame_sequencer_if.master bus
);

    seq_state_t                    state;
    logic [1:0]                    load_cnt;
    logic [1:0]                    drain_cnt;
    logic                          in_ready_q;
    logic                          start_q;
    logic                          out_valid_q;
    logic                          out_last_q;
    logic                          busy_q;
    logic [formatWidth-1:0]        out_real_q;
    logic [formatWidth-1:0]        out_imag_q;
    logic [POINTS*formatWidth-1:0] in_real_buf;
    logic [POINTS*formatWidth-1:0] in_imag_buf;
    logic [POINTS*formatWidth-1:0] res_real_buf;
    logic [POINTS*formatWidth-1:0] res_imag_buf;
    logic [POINTS*formatWidth-1:0] res_real_next;
    logic [POINTS*formatWidth-1:0] res_imag_next;
    logic                          in_beat;
    logic                          out_beat;
    logic                          capture;
    logic                          timeout_hit;
    logic                          wait_exit;

    assign in_beat       = in_ready_q && bus.in_valid;
    assign out_beat      = out_valid_q && bus.out_ready;
    assign capture       = (state == WAIT) && bus.gemm_done;
    assign wait_exit     = capture || timeout_hit;
    // A timed-out frame drains zeros so downstream still sees a complete frame.
    assign res_real_next = capture ? bus.output_real : '0;
    assign res_imag_next = capture ? bus.output_imag : '0;

`ifdef GEMM_FRAME_SEQUENCER_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       error_q;

    assign timeout_hit = (state == WAIT) && !bus.gemm_done &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.error   = 1'b0;
`endif

    frame_buffer4 #(.formatWidth(formatWidth)) u_input_frame (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_beat),
        .wr_slot   (load_cnt),
        .wr_real   (bus.in_real),
        .wr_imag   (bus.in_imag),
        .load_en   (1'b0),
        .load_real ('0),
        .load_imag ('0),
        .rd_real   (in_real_buf),
        .rd_imag   (in_imag_buf)
    );

    frame_buffer4 #(.formatWidth(formatWidth)) u_result_frame (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_slot   (2'd0),
        .wr_real   ('0),
        .wr_imag   ('0),
        .load_en   (wait_exit),
        .load_real (res_real_next),
        .load_imag (res_imag_next),
        .rd_real   (res_real_buf),
        .rd_imag   (res_imag_buf)
    );

    // out_real/out_imag are preloaded with the next slot so the result port stays registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOAD;
            load_cnt    <= '0;
            drain_cnt   <= '0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_beat) begin
                        load_cnt <= load_cnt + 2'd1;
                        if (load_cnt == 2'd3) begin
                            state      <= ISSUE;
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_exit) begin
                        state       <= DRAIN;
                        start_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        drain_cnt   <= '0;
                        out_real_q  <= get_slot(res_real_next, 2'd0);
                        out_imag_q  <= get_slot(res_imag_next, 2'd0);
                    end
                end
                DRAIN: begin
                    if (out_beat) begin
                        if (drain_cnt == 2'd3) begin
                            state       <= LOAD;
                            drain_cnt   <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            drain_cnt  <= drain_cnt + 2'd1;
                            out_real_q <= get_slot(res_real_buf, drain_cnt + 2'd1);
                            out_imag_q <= get_slot(res_imag_buf, drain_cnt + 2'd1);
                            out_last_q <= (drain_cnt == 2'd2);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.start      = start_q;
    assign bus.input_real = in_real_buf;
    assign bus.input_imag = in_imag_buf;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_real   = out_real_q;
    assign bus.out_imag   = out_imag_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gemm_frame_sequencer.sv
// Directed bench for gemm_frame_sequencer: frame-level model checked every cycle plus literal pins.
module tb_gemm_frame_sequencer;
    import fft_pkg::*;

    localparam int W  = FORMAT_WIDTH;
    localparam int BW = POINTS * W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gemm_frame_sequencer_if #(.formatWidth(W)) sif ();

    gemm_frame_sequencer #(
        .expWidth    (EXP_WIDTH),
        .sigWidth    (SIG_WIDTH),
        .formatWidth (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Frame-level model: samples accepted, whether gemm answered, results handed out.
    int         acc        = 0;
    int         drained    = 0;
    bit         done_seen  = 1'b0;
    int         start_age  = 0;
    int         dut_beats  = 0;
    logic       dut_valid_seen = 1'b0;
    logic [W-1:0] m_in_re [4];
    logic [W-1:0] m_in_im [4];
    logic [W-1:0] m_res_re [4];
    logic [W-1:0] m_res_im [4];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [BW-1:0] pack(input bit imag_sel);
        logic [BW-1:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            p[k*W +: W] = imag_sel ? m_in_im[k] : m_in_re[k];
        end
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       = 0;
            drained   = 0;
            done_seen = 1'b0;
            start_age = 0;
            for (int k = 0; k < 4; k++) begin
                m_in_re[k] = '0;
                m_in_im[k] = '0;
            end
        end else begin
            if (dut_valid_seen && sif.out_ready) begin
                dut_beats++;
            end
            if (done_seen && sif.out_ready) begin
                drained++;
                if (drained == 4) begin
                    acc       = 0;
                    drained   = 0;
                    done_seen = 1'b0;
                    start_age = 0;
                end
            end else if (acc == 4 && !done_seen) begin
                // The first start cycle does not look at done.
                if (start_age >= 1 && sif.gemm_done) begin
                    done_seen = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        m_res_re[k] = sif.output_real[k*W +: W];
                        m_res_im[k] = sif.output_imag[k*W +: W];
                    end
                end
                start_age++;
            end else if (acc < 4 && sif.in_valid) begin
                m_in_re[acc] = sif.in_real;
                m_in_im[acc] = sif.in_imag;
                acc++;
            end
        end
    end

    always @(negedge clk) begin
        dut_valid_seen = sif.out_valid;
        if (rst && cmp_en) begin
            check_output("in_ready", 64'(sif.in_ready), 64'(acc < 4));
            check_output("start", 64'(sif.start), 64'(acc == 4 && !done_seen));
            check_output("busy", 64'(sif.busy), 64'(acc == 4));
            check_output("out_valid", 64'(sif.out_valid), 64'(done_seen));
`ifndef GEMM_FRAME_SEQUENCER_TIMEOUT_EN
            check_output("error", 64'(sif.error), 64'd0);
`endif
            if (done_seen) begin
                check_output("out_real", 64'(sif.out_real), 64'(m_res_re[drained]));
                check_output("out_imag", 64'(sif.out_imag), 64'(m_res_im[drained]));
                check_output("out_last", 64'(sif.out_last), 64'(drained == 3));
            end
            if (acc == 4) begin
                check_output("input_real", 64'(sif.input_real), 64'(pack(1'b0)));
                check_output("input_imag", 64'(sif.input_imag), 64'(pack(1'b1)));
            end
        end
    end

    task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im, input int gap);
        bit rdy;
        bit accepted;
        accepted = 1'b0;
        sif.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_real  = re;
        sif.in_imag  = im;
        for (int i = 0; i < 64; i++) begin
            rdy = sif.in_ready;
            @(posedge clk);
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.in_real  = '1;
        sif.in_imag  = '1;
        check_output("sample_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic run_gemm(input int lat, input logic [BW-1:0] re, input logic [BW-1:0] im);
        repeat (lat) @(negedge clk);
        sif.gemm_done   = 1'b1;
        sif.output_real = re;
        sif.output_imag = im;
        @(negedge clk);
        sif.gemm_done   = 1'b0;
        sif.output_real = ~re;
        sif.output_imag = ~im;
    endtask

    task automatic drain_frame(input logic [3:0] pat, input int budget);
        for (int i = 0; i < budget; i++) begin
            sif.out_ready = pat[i % 4];
            @(negedge clk);
            if (sif.in_ready) break;
        end
        sif.out_ready = 1'b1;
        check_output("drain_done", 64'(sif.in_ready), 64'd1);
    endtask

    task automatic apply_stimulus4(input logic [BW-1:0] re, input logic [BW-1:0] im);
        for (int k = 0; k < 4; k++) begin
            send_sample(re[k*W +: W], im[k*W +: W], 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sif.in_valid    = 1'b0;
        sif.in_real     = '0;
        sif.in_imag     = '0;
        sif.output_real = '0;
        sif.output_imag = '0;
        sif.gemm_done   = 1'b0;
        sif.out_ready   = 1'b1;
        repeat (3) @(negedge clk);

        check_output("rst_in_ready", 64'(sif.in_ready), 64'd1);
        check_output("rst_start", 64'(sif.start), 64'd0);
        check_output("rst_busy", 64'(sif.busy), 64'd0);
        check_output("rst_out_valid", 64'(sif.out_valid), 64'd0);
        check_output("rst_out_last", 64'(sif.out_last), 64'd0);
        check_output("rst_error", 64'(sif.error), 64'd0);
        check_output("rst_input_real", 64'(sif.input_real), 64'd0);
        rst    = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Basic frame with hand-packed expectation.
        $display("[TB] frame 1: basic");
        send_sample(9'b1_1100_1000, 9'b1_1100_1000, 0);
        send_sample(9'b1_0111_1111, 9'b1_0111_1111, 0);
        send_sample(9'b0_1000_1000, 9'b0_1000_1000, 0);
        send_sample(9'b1_1100_1000, 9'b1_1100_1000, 0);
        check_output("f1_start", 64'(sif.start), 64'd1);
        check_output("f1_in_ready", 64'(sif.in_ready), 64'd0);
        check_output("f1_pack_real", 64'(sif.input_real),
                     64'({9'b1_1100_1000, 9'b0_1000_1000, 9'b1_0111_1111, 9'b1_1100_1000}));
        check_output("f1_pack_imag", 64'(sif.input_imag),
                     64'({9'b1_1100_1000, 9'b0_1000_1000, 9'b1_0111_1111, 9'b1_1100_1000}));
        run_gemm(3, {9'h10F, 9'h0F0, 9'h155, 9'h0AA}, {9'h1FF, 9'h004, 9'h002, 9'h001});
        check_output("f1_out_valid", 64'(sif.out_valid), 64'd1);
        check_output("f1_start_low", 64'(sif.start), 64'd0);
        check_output("f1_out_real0", 64'(sif.out_real), 64'h0AA);
        check_output("f1_out_imag0", 64'(sif.out_imag), 64'h001);
        check_output("f1_out_last0", 64'(sif.out_last), 64'd0);
        drain_frame(4'b1111, 40);
        check_output("f1_beats", 64'(dut_beats), 64'd4);

        // Backpressure during drain.
        $display("[TB] frame 2: backpressure");
        apply_stimulus4({9'h044, 9'h033, 9'h022, 9'h011}, {9'h1AB, 9'h0CD, 9'h0EF, 9'h123});
        run_gemm(5, {9'h1C3, 9'h03C, 9'h0A5, 9'h15A}, {9'h18E, 9'h071, 9'h1E1, 9'h01E});
        check_output("f2_out_valid", 64'(sif.out_valid), 64'd1);
        drain_frame(4'b1001, 60);
        check_output("f2_beats", 64'(dut_beats), 64'd8);

        // Input gaps with a stale done during LOAD and during the issue cycle.
        $display("[TB] frame 3: gaps and stale done");
        sif.gemm_done = 1'b1;
        send_sample(9'h101, 9'h0FE, 2);
        send_sample(9'h102, 9'h0FD, 0);
        send_sample(9'h103, 9'h0FC, 3);
        sif.gemm_done = 1'b0;
        check_output("f3_no_start", 64'(sif.start), 64'd0);
        check_output("f3_still_ready", 64'(sif.in_ready), 64'd1);
        send_sample(9'h104, 9'h0FB, 1);
        run_gemm(0, {4{9'h1FF}}, {4{9'h1FF}});
        check_output("f3_issue_done_ignored", 64'(sif.out_valid), 64'd0);
        check_output("f3_start_held", 64'(sif.start), 64'd1);
        run_gemm(2, {9'h0D4, 9'h0C3, 9'h0B2, 9'h0A1}, {9'h1D4, 9'h1C3, 9'h1B2, 9'h1A1});
        check_output("f3_out_valid", 64'(sif.out_valid), 64'd1);
        drain_frame(4'b0110, 60);
        check_output("f3_beats", 64'(dut_beats), 64'd12);

        // Reset in WAIT aborts the frame asynchronously.
        $display("[TB] frame 4: reset in wait");
        apply_stimulus4({9'h055, 9'h066, 9'h077, 9'h088}, {9'h099, 9'h0AA, 9'h0BB, 9'h0CC});
        repeat (2) @(negedge clk);
        check_output("f4_waiting", 64'(sif.start), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_output("f4_rst_start", 64'(sif.start), 64'd0);
        check_output("f4_rst_out_valid", 64'(sif.out_valid), 64'd0);
        check_output("f4_rst_busy", 64'(sif.busy), 64'd0);
        check_output("f4_rst_in_ready", 64'(sif.in_ready), 64'd1);
        check_output("f4_rst_input_real", 64'(sif.input_real), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fresh frame after the abort.
        $display("[TB] frame 5: after reset");
        apply_stimulus4({9'h00F, 9'h0F0, 9'h1E0, 9'h01E}, {9'h111, 9'h022, 9'h133, 9'h044});
        run_gemm(1, {9'h013, 9'h012, 9'h011, 9'h010}, {9'h123, 9'h122, 9'h121, 9'h120});
        check_output("f5_out_valid", 64'(sif.out_valid), 64'd1);
        check_output("f5_out_real0", 64'(sif.out_real), 64'h010);
        drain_frame(4'b1111, 40);
        check_output("f5_beats", 64'(dut_beats), 64'd16);
        check_output("f5_idle_out_valid", 64'(sif.out_valid), 64'd0);
        check_output("f5_idle_busy", 64'(sif.busy), 64'd0);

        cmp_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
